// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
//
// Purpose: drink vending sequencer. Accumulates coin credit, sells one of four
// drinks, and returns change (or refunds on cancel) one coin at a time through
// the hopper, using the largest denomination of 10/5/1 that fits the credit.
//
// Handshakes: disp_req / pay_req are levels raised by this block and held,
// with their payload (disp_drink / pay_coin) stable, until the partner pulses
// disp_ack / pay_ack for one cycle; the request drops at the following edge.
// Acks arriving while no request is pending are ignored. Coin, select and
// cancel are single-cycle strobes with no back-pressure: anything that cannot
// be accepted is either ignored (select, cancel) or refused with coin_reject.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   coin_valid/value    coin strobe, code 00=1 01=5 10=10 11=50
//   select_valid/drink_choose  purchase strobe and drink index
//   cancel              refund strobe
//   disp_req/drink/ack  drink motor handshake
//   pay_req/coin/ack    coin hopper handshake, code 00=1 01=5 10=10
//   total_coin          current credit (registered)
//   busy                state is not IDLE
//   coin_reject, deny   one-cycle refusal pulses
//   state_o             current FSM state for observation
// -----------------------------------------------------------------------------
module vend_sequencer #(
    parameter int unsigned PRICE_0    = 10,
    parameter int unsigned PRICE_1    = 15,
    parameter int unsigned PRICE_2    = 20,
    parameter int unsigned PRICE_3    = 25,
    parameter int unsigned MAX_CREDIT = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] drink_choose,
    input  logic       cancel,
    output logic       disp_req,
    output logic [1:0] disp_drink,
    input  logic       disp_ack,
    output logic       pay_req,
    output logic [1:0] pay_coin,
    input  logic       pay_ack,
    output logic [6:0] total_coin,
    output logic       busy,
    output logic       coin_reject,
    output logic       deny,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        PAY      = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam logic [7:0] P0    = 8'(PRICE_0);
    localparam logic [7:0] P1    = 8'(PRICE_1);
    localparam logic [7:0] P2    = 8'(PRICE_2);
    localparam logic [7:0] P3    = 8'(PRICE_3);
    localparam logic [7:0] MAX_C = 8'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [6:0] credit_q, credit_d;
    logic       disp_req_q, disp_req_d;
    logic [1:0] disp_drink_q, disp_drink_d;
    logic       pay_req_q, pay_req_d;
    logic [1:0] pay_coin_q, pay_coin_d;
    logic       coin_reject_q, coin_reject_d;
    logic       deny_q, deny_d;

    logic [7:0] credit_ext;
    logic [7:0] coin_amt;
    logic [7:0] coin_sum;
    logic [7:0] price_sel;
    logic [6:0] pay_amt;

    // Largest payout coin not exceeding the remaining credit.
    function automatic logic [1:0] denom_code(input logic [6:0] c);
        if (c >= 7'd10)     return 2'b10;
        else if (c >= 7'd5) return 2'b01;
        else                return 2'b00;
    endfunction

    always_comb begin
        case (coin_value)
            2'b00:   coin_amt = 8'd1;
            2'b01:   coin_amt = 8'd5;
            2'b10:   coin_amt = 8'd10;
            default: coin_amt = 8'd50;
        endcase
    end

    always_comb begin
        case (drink_choose)
            2'd0:    price_sel = P0;
            2'd1:    price_sel = P1;
            2'd2:    price_sel = P2;
            default: price_sel = P3;
        endcase
    end

    always_comb begin
        case (pay_coin_q)
            2'b10:   pay_amt = 7'd10;
            2'b01:   pay_amt = 7'd5;
            default: pay_amt = 7'd1;
        endcase
    end

    // Sums are formed one bit wider than the credit so an overflowing coin
    // is detected rather than wrapped.
    assign credit_ext = {1'b0, credit_q};
    assign coin_sum   = credit_ext + coin_amt;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_drink_d  = disp_drink_q;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != 7'd0) state_d = PAY;
                end else if (select_valid) begin
                    coin_reject_d = coin_valid;
                    if (credit_ext >= price_sel) begin
                        credit_d     = 7'(credit_ext - price_sel);
                        disp_drink_d = drink_choose;
                        state_d      = DISPENSE;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= MAX_C) credit_d = coin_sum[6:0];
                    else                   coin_reject_d = 1'b1;
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_valid;
                if (disp_ack) state_d = (credit_q != 7'd0) ? PAY : IDLE;
            end
            PAY: begin
                coin_reject_d = coin_valid;
                // pay_coin never exceeds credit, so this cannot underflow.
                if (pay_ack) begin
                    credit_d = credit_q - pay_amt;
                    state_d  = GAP;
                end
            end
            GAP: begin
                coin_reject_d = coin_valid;
                state_d       = (credit_q != 7'd0) ? PAY : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Request outputs are registered copies of the next state so they
        // change exactly at the state-change edge.
        disp_req_d = (state_d == DISPENSE);
        pay_req_d  = (state_d == PAY);
        pay_coin_d = (state_d == PAY) ? denom_code(credit_d) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= 7'd0;
            disp_req_q    <= 1'b0;
            disp_drink_q  <= 2'd0;
            pay_req_q     <= 1'b0;
            pay_coin_q    <= 2'd0;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            disp_drink_q  <= disp_drink_d;
            pay_req_q     <= pay_req_d;
            pay_coin_q    <= pay_coin_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
        end
    end

    assign disp_req    = disp_req_q;
    assign disp_drink  = disp_drink_q;
    assign pay_req     = pay_req_q;
    assign pay_coin    = pay_coin_q;
    assign total_coin  = credit_q;
    assign busy        = (state_q != IDLE);
    assign coin_reject = coin_reject_q;
    assign deny        = deny_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_sequencer: directed stimulus for vend_sequencer with a behavioural
// reference model (credit + mode), a per-cycle compare, a payout scoreboard
// and hand-computed literal checks for each scenario.
// -----------------------------------------------------------------------------
module tb_vend_sequencer;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       select_valid;
    logic [1:0] drink_choose;
    logic       cancel;
    logic       disp_req;
    logic [1:0] disp_drink;
    logic       disp_ack;
    logic       pay_req;
    logic [1:0] pay_coin;
    logic       pay_ack;
    logic [6:0] total_coin;
    logic       busy;
    logic       coin_reject;
    logic       deny;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    vend_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .select_valid (select_valid),
        .drink_choose (drink_choose),
        .cancel       (cancel),
        .disp_req     (disp_req),
        .disp_drink   (disp_drink),
        .disp_ack     (disp_ack),
        .pay_req      (pay_req),
        .pay_coin     (pay_coin),
        .pay_ack      (pay_ack),
        .total_coin   (total_coin),
        .busy         (busy),
        .coin_reject  (coin_reject),
        .deny         (deny),
        .state_o      (state_o)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;
    logic [1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 waiting for motor, 2 waiting for hopper, 3 gap cycle
    int m_credit = 0;
    int m_mode   = 0;
    int m_drink  = 0;
    bit m_rej    = 1'b0;
    bit m_deny   = 1'b0;
    int price_tab[4] = '{10, 15, 20, 25};
    int coin_tab[4]  = '{1, 5, 10, 50};

    function automatic int denom(input int c);
        if (c >= 10) return 10;
        if (c >= 5)  return 5;
        return 1;
    endfunction

    function automatic int code_of(input int amount);
        if (amount == 10) return 2;
        if (amount == 5)  return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        m_rej  <= 1'b0;
        m_deny <= 1'b0;
        if (reset) begin
            m_credit <= 0;
            m_mode   <= 0;
            m_drink  <= 0;
        end else if (m_mode == 0) begin
            if (coin_valid && (cancel || select_valid)) m_rej <= 1'b1;
            if (cancel) begin
                if (m_credit > 0) m_mode <= 2;
            end else if (select_valid) begin
                if (m_credit >= price_tab[drink_choose]) begin
                    m_credit <= m_credit - price_tab[drink_choose];
                    m_drink  <= int'(drink_choose);
                    m_mode   <= 1;
                end else begin
                    m_deny <= 1'b1;
                end
            end else if (coin_valid) begin
                if (m_credit + coin_tab[coin_value] <= 99)
                    m_credit <= m_credit + coin_tab[coin_value];
                else
                    m_rej <= 1'b1;
            end
        end else begin
            if (coin_valid) m_rej <= 1'b1;
            if (m_mode == 1 && disp_ack) m_mode <= (m_credit > 0) ? 2 : 0;
            if (m_mode == 2 && pay_ack) begin
                m_credit <= m_credit - denom(m_credit);
                m_mode   <= 3;
            end
            if (m_mode == 3) m_mode <= (m_credit > 0) ? 2 : 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("total_coin", int'(total_coin), m_credit);
            chk("busy", int'(busy), int'(m_mode != 0));
            chk("disp_req", int'(disp_req), int'(m_mode == 1));
            if (m_mode == 1) chk("disp_drink", int'(disp_drink), m_drink);
            chk("pay_req", int'(pay_req), int'(m_mode == 2));
            if (m_mode == 2) chk("pay_coin", int'(pay_coin), code_of(denom(m_credit)));
            chk("coin_reject", int'(coin_reject), int'(m_rej));
            chk("deny", int'(deny), int'(m_deny));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] d);
        select_valid = 1'b1;
        drink_choose = d;
        tick();
        select_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic ack_disp(input int delay);
        int n = 0;
        while (!disp_req && n < 40) begin
            tick();
            n++;
        end
        if (!disp_req) begin
            fail("disp_req_timeout");
            return;
        end
        repeat (delay) tick();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    task automatic ack_pay(input int delay);
        int n = 0;
        while (!pay_req && n < 40) begin
            tick();
            n++;
        end
        if (!pay_req) begin
            fail("pay_req_timeout");
            return;
        end
        if (exp_q.size() == 0) fail("unexpected_payout");
        else chk("payout_coin", int'(pay_coin), int'(exp_q.pop_front()));
        repeat (delay) tick();
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) fail("idle_timeout");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin_value = 2'b00;
        select_valid = 1'b0; drink_choose = 2'd0;
        cancel = 1'b0; disp_ack = 1'b0; pay_ack = 1'b0;
        tick();
        tick();
        check_en = 1'b1;
        chk("rst_total", int'(total_coin), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_disp_req", int'(disp_req), 0);
        chk("rst_disp_drink", int'(disp_drink), 0);
        chk("rst_pay_req", int'(pay_req), 0);
        chk("rst_pay_coin", int'(pay_coin), 0);
        chk("rst_reject", int'(coin_reject), 0);
        chk("rst_deny", int'(deny), 0);
        reset = 1'b0;
        tick();

        // 10, 5, 10 then drink 1; change 10 paid as two 10s? no: 25-15=10 -> one 10
        put_coin(2'b10); put_coin(2'b01); put_coin(2'b10);
        chk("t1_total25", int'(total_coin), 25);
        chk("t1_model25", m_credit, 25);
        select(2'd1);
        chk("t1_disp_req", int'(disp_req), 1);
        chk("t1_disp_drink", int'(disp_drink), 1);
        chk("t1_total10", int'(total_coin), 10);
        exp_q.push_back(2'b10);
        ack_disp(2);
        ack_pay(0);
        chk("t1_gap_pay_req", int'(pay_req), 0);
        chk("t1_gap_busy", int'(busy), 1);
        tick();
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_total0", int'(total_coin), 0);

        // Credit 5, drink 0 denied
        put_coin(2'b01);
        select(2'd0);
        chk("t2_deny", int'(deny), 1);
        chk("t2_total5", int'(total_coin), 5);
        chk("t2_busy", int'(busy), 0);
        tick();
        chk("t2_deny_pulse", int'(deny), 0);
        do_cancel();
        exp_q.push_back(2'b01);
        ack_pay(1);
        wait_idle();

        // Credit 60, coin 50 rejected, cancel pays six 10s
        put_coin(2'b11); put_coin(2'b10);
        put_coin(2'b11);
        chk("t3_reject", int'(coin_reject), 1);
        chk("t3_total60", int'(total_coin), 60);
        tick();
        chk("t3_reject_pulse", int'(coin_reject), 0);
        do_cancel();
        repeat (6) exp_q.push_back(2'b10);
        ack_pay(0);
        ack_pay(0);
        // In GAP: every strobe at once; only the coin refusal shows
        coin_valid = 1'b1; coin_value = 2'b00; select_valid = 1'b1; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0;
        chk("t3_gap_reject", int'(coin_reject), 1);
        repeat (4) ack_pay(0);
        wait_idle();
        chk("t3_total0", int'(total_coin), 0);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Select drink 2 with a coin in the same cycle, credit 20
        put_coin(2'b10); put_coin(2'b10);
        select_valid = 1'b1; drink_choose = 2'd2;
        coin_valid = 1'b1; coin_value = 2'b10;
        tick();
        select_valid = 1'b0; coin_valid = 1'b0;
        chk("t4_reject", int'(coin_reject), 1);
        chk("t4_disp_req", int'(disp_req), 1);
        chk("t4_disp_drink", int'(disp_drink), 2);
        chk("t4_total0", int'(total_coin), 0);
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
        put_coin(2'b00);
        ack_disp(1);
        chk("t4_idle", int'(busy), 0);

        // Credit 7, cancel: 5, 1, 1 with 3-cycle acks
        put_coin(2'b01); put_coin(2'b00); put_coin(2'b00);
        chk("t5_total7", int'(total_coin), 7);
        do_cancel();
        exp_q.push_back(2'b01); exp_q.push_back(2'b00); exp_q.push_back(2'b00);
        repeat (3) ack_pay(3);
        wait_idle();
        chk("t5_total0", int'(total_coin), 0);

        // Reset during PAY with credit 16
        put_coin(2'b10); put_coin(2'b01); put_coin(2'b00);
        do_cancel();
        chk("t6_pay_req", int'(pay_req), 1);
        chk("t6_pay_coin", int'(pay_coin), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_total0", int'(total_coin), 0);
        chk("t6_pay_req_low", int'(pay_req), 0);

        // Credit ceiling: reach exactly 99, then refuse a 1
        disp_ack = 1'b1; pay_ack = 1'b1;
        tick();
        disp_ack = 1'b0; pay_ack = 1'b0;
        put_coin(2'b11);
        repeat (4) put_coin(2'b10);
        put_coin(2'b01);
        repeat (4) put_coin(2'b00);
        chk("t7_total99", int'(total_coin), 99);
        put_coin(2'b00);
        chk("t7_reject", int'(coin_reject), 1);
        chk("t7_total_hold", int'(total_coin), 99);
        do_cancel();
        repeat (9) exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        repeat (4) exp_q.push_back(2'b00);
        repeat (14) ack_pay(0);
        wait_idle();
        chk("t7_total0", int'(total_coin), 0);

        // Cancel with no credit is ignored; exact-price drink 3
        do_cancel();
        chk("t8_cancel_ignored", int'(busy), 0);
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
        select(2'd3);
        chk("t8_disp_drink", int'(disp_drink), 3);
        chk("t8_total0", int'(total_coin), 0);
        ack_disp(0);
        chk("t8_idle", int'(busy), 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
